// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   STATS_CNT_W : width of the optional per-requester grant counters
//   rr_next     : round-robin search over up to RR_MAX_N requesters
package handshake_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned STATS_CNT_W = 8;
    localparam int unsigned RR_MAX_N    = 8;
    localparam int unsigned RR_IDX_W    = 3;

    // First set bit of valid searching last+1, last+2, ... modulo n (n >= 2).
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_N-1:0] valid,
        input logic [RR_IDX_W-1:0] last,
        input int unsigned         n
    );
        logic [RR_IDX_W-1:0] res;
        logic                found;
        int unsigned         cand;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            cand = (32'(last) + k) % n;
            if (!found && (k <= n) && valid[RR_IDX_W'(cand)]) begin
                res   = RR_IDX_W'(cand);
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin priority search, reusable by other schedulers.
//   valid [N]    : request vector
//   last  [ID_W] : most recently served index; search starts at last+1
//   any          : at least one request present
//   idx   [ID_W] : chosen index (0 when any is low)
module rr_pick
    import handshake_arb_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] last,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [RR_MAX_N-1:0] valid_ext;

    always_comb begin
        valid_ext = RR_MAX_N'(valid);
        any       = |valid;
        idx       = ID_W'(rr_next(valid_ext, RR_IDX_W'(last), N));
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one downstream ready/valid channel between N
// upstream requesters. A granted requester owns the channel until its beat
// transfers (or it drops valid, which aborts the grant).
//   CLK, RESET        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : per-requester handshake
//   in_data           : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data/out_id : downstream handshake + granted index
//   grant_cnt         : per-requester saturating transfer counters, present
//                       only when HANDSHAKE_RR_ARBITER_STATS_EN is defined
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ID_W   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic [N*DATA_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [ID_W-1:0]       out_id
`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
    ,
    output logic [N*STATS_CNT_W-1:0] grant_cnt
`endif
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q,  last_d;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic [DATA_W-1:0] lane_data [N];

    // Unpack payload lanes for the output mux.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_pick (
        .valid (in_valid),
        .last  (last_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // State, grant and priority pointer registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state and downstream/upstream handshake outputs.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_id    = '0;
        in_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                out_valid         = in_valid[grant_q];
                out_data          = lane_data[grant_q];
                out_id            = grant_q;
                in_ready[grant_q] = out_ready;
                if (!in_valid[grant_q]) begin
                    // Upstream dropped valid: abort, keep pointer so it retains priority.
                    state_d = IDLE;
                end else if (out_ready) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
    logic xfer;
    assign xfer = (state_q == LOCKED) && in_valid[grant_q] && out_ready;

    // Saturating completed-transfer counters, one per requester.
    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic [STATS_CNT_W-1:0] cnt_q;
        always_ff @(posedge CLK) begin
            if (RESET) begin
                cnt_q <= '0;
            end else if (xfer && (grant_q == ID_W'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q;
    end
`endif

endmodule
